// File: rtl/rv32_mem_pkg.sv
// Shared definitions for the RV32 data-memory path.
// Contents:
//   F3_*     : FUNC3 encodings of the RV32 load/store access types
//   state_e  : responder FSM states
//   CNT_W    : width of the access-latency counter (holds LATENCY-1, max 14)
//   is_unsigned_f3 : true for the zero-extending load encodings (BU/HU)
package rv32_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    // BU/HU only exist as loads; a store carrying them is rejected.
    function automatic logic is_unsigned_f3(input logic [2:0] f3);
        return (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/mem_align_unit.sv
// Combinational lane steering for RV32 byte/half/word accesses.
// Ports:
//   word_i        : 32-bit memory word containing the addressed location
//   lane_i        : byte lane within the word (ADDRESS[1:0])
//   func3_i       : access type (B, H, W, BU, HU)
//   store_data_i  : raw store data from the pipeline
//   load_data_o   : load result, sign or zero extended
//   byte_en_o     : per-byte write enable for a store
//   store_data_o  : store data replicated onto every lane it may hit
//   misalign_o    : access is misaligned or FUNC3 is undefined
module mem_align_unit
    import rv32_mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  lane_i,
    input  logic [2:0]  func3_i,
    input  logic [31:0] store_data_i,
    output logic [31:0] load_data_o,
    output logic [3:0]  byte_en_o,
    output logic [31:0] store_data_o,
    output logic        misalign_o
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        lane_byte = word_i[8*lane_i +: 8];
        lane_half = lane_i[1] ? word_i[31:16] : word_i[15:0];
    end

    always_comb begin
        load_data_o  = '0;
        byte_en_o    = '0;
        store_data_o = store_data_i;
        misalign_o   = 1'b0;
        case (func3_i)
            F3_B, F3_BU: begin
                load_data_o  = (func3_i == F3_B) ? {{24{lane_byte[7]}}, lane_byte}
                                                 : {24'd0, lane_byte};
                byte_en_o    = 4'b0001 << lane_i;
                // Replicating the byte lets the enable pick the lane.
                store_data_o = {4{store_data_i[7:0]}};
            end
            F3_H, F3_HU: begin
                misalign_o   = lane_i[0];
                load_data_o  = (func3_i == F3_H) ? {{16{lane_half[15]}}, lane_half}
                                                 : {16'd0, lane_half};
                byte_en_o    = lane_i[1] ? 4'b1100 : 4'b0011;
                store_data_o = {2{store_data_i[15:0]}};
            end
            F3_W: begin
                misalign_o   = (lane_i != 2'b00);
                load_data_o  = word_i;
                byte_en_o    = 4'b1111;
            end
            default: begin
                misalign_o   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory responder for the EX/MEM stage.
// Accepts a load or store in IDLE, spends LATENCY cycles in ACCESS, then
// presents the result for one DONE cycle while BUSYWAIT stalls the pipeline.
// Ports:
//   CLK        : clock, rising edge
//   RESET      : asynchronous active-low reset
//   MEMREAD    : load request
//   MEMWRITE   : store request
//   FUNC3      : access type (B, H, W, BU, HU)
//   ADDRESS    : byte address; wraps modulo 4*DEPTH_WORDS
//   WRITEDATA  : store data
//   READDATA   : extended load result, held until the next load completes
//   BUSYWAIT   : stall request to the pipeline registers
//   MEM_ERROR  : one-cycle pulse in DONE for a rejected access
module data_mem_responder
    import rv32_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 4
)(
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MEMREAD,
    input  logic        MEMWRITE,
    input  logic [2:0]  FUNC3,
    input  logic [31:0] ADDRESS,
    input  logic [31:0] WRITEDATA,
    output logic [31:0] READDATA,
    output logic        BUSYWAIT,
    output logic        MEM_ERROR
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int AW    = IDX_W + 2;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [2:0]         func3_q, func3_d;
    logic               rd_q, rd_d;
    logic               wr_q, wr_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;

    logic [31:0]        rd_word;
    logic [31:0]        load_data;
    logic [3:0]         byte_en;
    logic [31:0]        st_data;
    logic               misalign;
    logic               access_err;
    logic               finish;
    logic               mem_we;
    logic [IDX_W-1:0]   rd_idx;
    logic [IDX_W-1:0]   wr_idx;
    logic               unused_addr_hi;

    // Only the word index and lane are kept; higher address bits alias.
    assign unused_addr_hi = ^ADDRESS[31:AW];

    mem_align_unit u_align (
        .word_i       (rd_word),
        .lane_i       (addr_q[1:0]),
        .func3_i      (func3_q),
        .store_data_i (wdata_q),
        .load_data_o  (load_data),
        .byte_en_o    (byte_en),
        .store_data_o (st_data),
        .misalign_o   (misalign)
    );

    assign access_err = misalign
                      | (rd_q & wr_q)
                      | (wr_q & is_unsigned_f3(func3_q));
    assign finish     = (state_q == ST_ACCESS) && (cnt_q == '0);
    assign mem_we     = finish && wr_q && !access_err;
    assign wr_idx     = addr_q[AW-1:2];
    // The read port is registered, so in IDLE it is pointed at the incoming
    // address; the word is then ready even when LATENCY is 1.
    assign rd_idx     = (state_q == ST_IDLE) ? ADDRESS[AW-1:2] : addr_q[AW-1:2];

    // Next-state and output logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        func3_d  = func3_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        rdata_d  = rdata_q;
        err_d    = 1'b0;
        BUSYWAIT = 1'b0;
        case (state_q)
            ST_IDLE: begin
                BUSYWAIT = RESET & (MEMREAD | MEMWRITE);
                if (MEMREAD || MEMWRITE) begin
                    addr_d  = ADDRESS[AW-1:0];
                    wdata_d = WRITEDATA;
                    func3_d = FUNC3;
                    rd_d    = MEMREAD;
                    wr_d    = MEMWRITE;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                BUSYWAIT = RESET;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    if (access_err) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else if (rd_q) begin
                        rdata_d = load_data;
                    end
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Request lines still belong to the finished instruction.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            func3_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            func3_q <= func3_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign READDATA  = rdata_q;
    assign MEM_ERROR = err_q;

    // One byte-wide array per lane so each byte enable maps to its own RAM.
    // The array is never reset; a reset simply stops mem_we from firing.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH_WORDS];
            logic [7:0] rd_byte_q;

            always_ff @(posedge CLK) begin
                if (mem_we && byte_en[gi]) begin
                    lane_mem[wr_idx] <= st_data[8*gi +: 8];
                end
                rd_byte_q <= lane_mem[rd_idx];
            end

            assign rd_word[8*gi +: 8] = rd_byte_q;
        end
    endgenerate

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        MEMREAD;
    logic        MEMWRITE;
    logic [2:0]  FUNC3;
    logic [31:0] ADDRESS;
    logic [31:0] WRITEDATA;
    logic [31:0] READDATA;
    logic        BUSYWAIT;
    logic        MEM_ERROR;

    int checks = 0;
    int errors = 0;

    localparam int EXP_BUSY = 5;   // LATENCY(4) + 1

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp_data;
        logic        exp_err;
        logic        chk_data;
    } txn_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic        chk_data;
        int          busy;
    } exp_t;

    exp_t sb[$];

    data_mem_responder dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .MEMREAD   (MEMREAD),
        .MEMWRITE  (MEMWRITE),
        .FUNC3     (FUNC3),
        .ADDRESS   (ADDRESS),
        .WRITEDATA (WRITEDATA),
        .READDATA  (READDATA),
        .BUSYWAIT  (BUSYWAIT),
        .MEM_ERROR (MEM_ERROR)
    );

    always #5 CLK = ~CLK;

    function automatic txn_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] ed, input logic ee, input logic cd);
        txn_t t;
        t.rd = rd; t.wr = wr; t.f3 = f3; t.a = a; t.wd = wd;
        t.exp_data = ed; t.exp_err = ee; t.chk_data = cd;
        return t;
    endfunction

    // Drive a request from IDLE (called #1 after a rising edge), count the
    // stall cycles, sample the DONE cycle, and return #1 after the DONE edge
    // with the request lines left as they were.
    task automatic issue(input txn_t t, output int busy, output logic [31:0] data,
                         output logic err);
        logic done;
        MEMREAD = t.rd; MEMWRITE = t.wr; FUNC3 = t.f3;
        ADDRESS = t.a; WRITEDATA = t.wd;
        busy = 0; data = 'x; err = 1'bx; done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge CLK);
            if (BUSYWAIT === 1'b1) busy++;
            else begin
                data = READDATA; err = MEM_ERROR; done = 1'b1;
            end
        end
        $display("txn rd=%0d wr=%0d f3=%03b addr=%08h wd=%08h busy=%0d data=%08h err=%0b",
                 t.rd, t.wr, t.f3, t.a, t.wd, busy, data, err);
        @(posedge CLK); #1;
    endtask

    task automatic clear_req();
        MEMREAD = 1'b0; MEMWRITE = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b0; clear_req(); FUNC3 = 3'b010; ADDRESS = '0; WRITEDATA = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        checks++;
        if (READDATA !== 32'h0 || BUSYWAIT !== 1'b0 || MEM_ERROR !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got rd=%08h bw=%b err=%b want 00000000/0/0",
                     READDATA, BUSYWAIT, MEM_ERROR);
        end
        @(posedge CLK); #1; RESET = 1'b1;
        repeat (2) @(negedge CLK);
        checks++;
        if (BUSYWAIT !== 1'b0) begin
            errors++;
            $display("FAIL idle_busywait got %b want 0", BUSYWAIT);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_word_and_subword();
        txn_t tl[$];
        int busy; logic [31:0] d; logic e; exp_t x;
        tl.push_back(mk(0, 1, 3'b010, 32'h10, 32'h12345678, '0, 0, 0));
        tl.push_back(mk(1, 0, 3'b010, 32'h10, '0, 32'h12345678, 0, 1));
        tl.push_back(mk(0, 1, 3'b000, 32'h11, 32'h000000AB, '0, 0, 0));
        tl.push_back(mk(0, 1, 3'b001, 32'h12, 32'h00008001, '0, 0, 0));
        tl.push_back(mk(1, 0, 3'b010, 32'h10, '0, 32'h8001AB78, 0, 1));
        tl.push_back(mk(1, 0, 3'b000, 32'h11, '0, 32'hFFFFFFAB, 0, 1));
        tl.push_back(mk(1, 0, 3'b100, 32'h11, '0, 32'h000000AB, 0, 1));
        tl.push_back(mk(1, 0, 3'b001, 32'h12, '0, 32'hFFFF8001, 0, 1));
        tl.push_back(mk(1, 0, 3'b101, 32'h12, '0, 32'h00008001, 0, 1));
        tl.push_back(mk(1, 0, 3'b000, 32'h10, '0, 32'h00000078, 0, 1));
        foreach (tl[i]) begin
            sb.push_back('{tl[i].exp_data, tl[i].exp_err, tl[i].chk_data, EXP_BUSY});
            issue(tl[i], busy, d, e);
            clear_req();
            x = sb.pop_front();
            checks++;
            if (busy !== x.busy) begin
                errors++; $display("FAIL access_busy[%0d] got %0d want %0d", i, busy, x.busy);
            end
            checks++;
            if (e !== x.err) begin
                errors++; $display("FAIL access_err[%0d] got %b want %b", i, e, x.err);
            end
            if (x.chk_data) begin
                checks++;
                if (d !== x.data) begin
                    errors++; $display("FAIL access_data[%0d] got %08h want %08h", i, d, x.data);
                end
            end
        end
    endtask

    task automatic test_errors();
        txn_t tl[$];
        int busy; logic [31:0] d; logic e; exp_t x;
        tl.push_back(mk(1, 0, 3'b010, 32'h13, '0, 32'h0, 1, 1));
        tl.push_back(mk(0, 1, 3'b010, 32'h20, 32'h11223344, '0, 0, 0));
        tl.push_back(mk(1, 0, 3'b010, 32'h20, '0, 32'h11223344, 0, 1));
        tl.push_back(mk(0, 1, 3'b001, 32'h21, 32'h0000FFFF, 32'h0, 1, 1));
        tl.push_back(mk(1, 0, 3'b010, 32'h20, '0, 32'h11223344, 0, 1));
        tl.push_back(mk(1, 1, 3'b010, 32'h20, 32'h0, 32'h0, 1, 1));
        tl.push_back(mk(1, 0, 3'b010, 32'h20, '0, 32'h11223344, 0, 1));
        tl.push_back(mk(1, 0, 3'b011, 32'h20, '0, 32'h0, 1, 1));
        tl.push_back(mk(0, 1, 3'b100, 32'h20, 32'h000000EE, 32'h0, 1, 1));
        tl.push_back(mk(1, 0, 3'b010, 32'h20, '0, 32'h11223344, 0, 1));
        foreach (tl[i]) begin
            sb.push_back('{tl[i].exp_data, tl[i].exp_err, tl[i].chk_data, EXP_BUSY});
            issue(tl[i], busy, d, e);
            clear_req();
            x = sb.pop_front();
            checks++;
            if (busy !== x.busy) begin
                errors++; $display("FAIL error_busy[%0d] got %0d want %0d", i, busy, x.busy);
            end
            checks++;
            if (e !== x.err) begin
                errors++; $display("FAIL error_flag[%0d] got %b want %b", i, e, x.err);
            end
            if (x.chk_data) begin
                checks++;
                if (d !== x.data) begin
                    errors++; $display("FAIL error_data[%0d] got %08h want %08h", i, d, x.data);
                end
            end
        end
    endtask

    task automatic test_reset_mid_access();
        int busy; logic [31:0] d; logic e; exp_t x;
        issue(mk(0, 1, 3'b010, 32'h30, 32'h0BADF00D, '0, 0, 0), busy, d, e);
        clear_req();
        // Start the store that will be aborted.
        MEMWRITE = 1'b1; FUNC3 = 3'b010; ADDRESS = 32'h30; WRITEDATA = 32'hDEADBEEF;
        @(posedge CLK); #1;          // 1st ACCESS cycle
        @(posedge CLK); #1;          // 2nd ACCESS cycle
        RESET = 1'b0;
        #1;
        checks++;
        if (BUSYWAIT !== 1'b0) begin
            errors++; $display("FAIL reset_mid_busywait got %b want 0", BUSYWAIT);
        end
        clear_req();
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if (READDATA !== 32'h0 || MEM_ERROR !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_outputs got rd=%08h err=%b want 00000000/0", READDATA, MEM_ERROR);
        end
        RESET = 1'b1;
        @(posedge CLK); #1;
        sb.push_back('{32'h0BADF00D, 1'b0, 1'b1, EXP_BUSY});
        issue(mk(1, 0, 3'b010, 32'h30, '0, '0, 0, 1), busy, d, e);
        clear_req();
        x = sb.pop_front();
        checks++;
        if (d !== x.data || e !== x.err || busy !== x.busy) begin
            errors++;
            $display("FAIL reset_abort_store got data=%08h err=%b busy=%0d want %08h/%b/%0d",
                     d, e, busy, x.data, x.err, x.busy);
        end
    endtask

    task automatic test_wrap_back_to_back();
        int busy; logic [31:0] d; logic e; exp_t x;
        issue(mk(0, 1, 3'b010, 32'h400, 32'h55AA55AA, '0, 0, 0), busy, d, e);
        clear_req();
        sb.push_back('{32'h55AA55AA, 1'b0, 1'b1, EXP_BUSY});
        sb.push_back('{32'h55AA55AA, 1'b0, 1'b1, EXP_BUSY});
        // Request held straight through DONE: the second pass must start from
        // IDLE and show the full stall again.
        for (int k = 0; k < 2; k++) begin
            issue(mk(1, 0, 3'b010, 32'h000, '0, '0, 0, 1), busy, d, e);
            x = sb.pop_front();
            checks++;
            if (d !== x.data || e !== x.err) begin
                errors++;
                $display("FAIL wrap_load[%0d] got data=%08h err=%b want %08h/%b", k, d, e, x.data, x.err);
            end
            checks++;
            if (busy !== x.busy) begin
                errors++; $display("FAIL b2b_busy[%0d] got %0d want %0d", k, busy, x.busy);
            end
        end
        clear_req();
        @(negedge CLK);
        checks++;
        if (BUSYWAIT !== 1'b0) begin
            errors++; $display("FAIL b2b_idle_after got %b want 0", BUSYWAIT);
        end
        @(posedge CLK); #1;
    endtask

    initial begin
        test_reset();
        test_word_and_subword();
        test_errors();
        test_reset_mid_access();
        test_wrap_back_to_back();
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL scoreboard_leftover got %0d want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the EX/MEM stage's data access port (MEMREAD/MEMWRITE/FUNC3 from the pipeline registers).
- Generates the BUSYWAIT that stalls IF_ID, ID_EX and EX_MEM.
- Models a multi-cycle word-organised data memory with RV32 byte/half/word loads (sign or zero extended) and stores.
- Fixed configurable access latency.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words in the array; power of two.
LATENCY, 4, cycles spent in ACCESS state; legal range 1..15.

Ports:
CLK  input  1  clock; all state updates on the rising edge.
RESET  input  1  asynchronous, active-low reset (asserted when 0).
MEMREAD  input  1  load request from EX_MEM stage.
MEMWRITE  input  1  store request from EX_MEM stage.
FUNC3  input  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU.
ADDRESS  input  32  byte address (ALU result).
WRITEDATA  input  32  store data; low byte/half used for SB/SH.
READDATA  output  32  extended load result; valid in DONE.
BUSYWAIT  output  1  stall request to all pipeline registers.
MEM_ERROR  output  1  one-cycle pulse in DONE for a rejected access.

Behaviour:
- Reset (RESET=0, any time, asynchronous):
  - FSM goes to IDLE; counter 0; READDATA 0; MEM_ERROR 0; BUSYWAIT 0.
  - Memory array contents are not cleared.
  - Reset during ACCESS aborts the access; a pending store is not written.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - BUSYWAIT = MEMREAD | MEMWRITE, combinational, same cycle as the request.
  - On an edge with a request: latch ADDRESS, WRITEDATA, FUNC3 and op; counter <= LATENCY-1; go to ACCESS.
- ACCESS:
  - BUSYWAIT = 1.
  - Counter decrements each edge while nonzero.
  - On the edge where counter==0: perform the store or capture the load into READDATA; set MEM_ERROR if rejected; go to DONE.
- DONE:
  - BUSYWAIT = 0; READDATA held; MEM_ERROR high only in this cycle.
  - Pipeline advances at the end of this cycle.
  - Request inputs are ignored (they still belong to the completed instruction); next edge goes unconditionally to IDLE.
  - READDATA holds its value through IDLE until the next load completes.
- Stall length: LATENCY+1 cycles with BUSYWAIT=1, then 1 DONE cycle. Back-to-back requests have 1 IDLE cycle between them.
- Addressing:
  - Word index = ADDRESS[log2(DEPTH_WORDS)+1:2]; upper bits ignored, so addresses wrap modulo 4*DEPTH_WORDS.
  - Byte lane = ADDRESS[1:0].
- Loads:
  - B/BU select the lane byte; H/HU select the half at ADDRESS[1].
  - B/H sign-extend bit 7/15; BU/HU zero-extend; W returns the full word.
- Stores:
  - SB writes only the selected byte; SH writes only the selected half; SW writes the whole word.
  - Other bytes of the word are unchanged.
- Rejected access (MEM_ERROR=1; no array write; READDATA <= 0). Full FSM timing still applies in every case:
  - Misaligned H/HU/SH with ADDRESS[0]=1.
  - Misaligned W with ADDRESS[1:0]!=0.
  - Undefined FUNC3 (011, 110, 111), or 100/101 on a store.
  - MEMREAD and MEMWRITE both high.
- Request deasserted mid-access (should not occur under stall): the latched request completes regardless.

Decomposition:
- Shared package rv32_mem_pkg:
  - FUNC3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State enum: ST_IDLE, ST_ACCESS, ST_DONE.
  - Counter width constant.
- One combinational sub-module, mem_align_unit:
  - Inputs: word, lane, FUNC3.
  - Outputs: extended load data, store byte-enable[3:0], aligned store data, misalign/illegal flag.
  - Reused later by a data cache.

Test Plan:
- Reset and idle:
  - Hold RESET=0 for 2 cycles.
  - Expect READDATA=0, BUSYWAIT=0, MEM_ERROR=0.
  - Release with no request: BUSYWAIT stays 0.
- SW then LW, LATENCY=4:
  - Store 32'h12345678 to 0x10: BUSYWAIT high for exactly 5 cycles starting the request cycle, then 1 low DONE cycle.
  - LW 0x10 gives READDATA=32'h12345678 in DONE.
- Byte/half stores and extension:
  - After the above, SB 0xAB to 0x11 and SH 0x8001 to 0x12.
  - LW 0x10 = 32'h8001AB78.
  - LB 0x11 = 32'hFFFFFFAB; LBU 0x11 = 32'h000000AB.
  - LH 0x12 = 32'hFFFF8001; LHU 0x12 = 32'h00008001.
- Errors:
  - LW 0x13 gives MEM_ERROR pulse in DONE, READDATA=0.
  - SH 0x21 with data 0xFFFF gives MEM_ERROR; a later LW 0x20 is unchanged.
  - MEMREAD=MEMWRITE=1 gives MEM_ERROR with no write.
- Reset mid-operation:
  - Drive SW 0xDEADBEEF to 0x30; assert RESET in the 2nd ACCESS cycle.
  - BUSYWAIT drops immediately.
  - After release, LW 0x30 returns the prior contents (not 0xDEADBEEF).
- Wrap and back-to-back, DEPTH_WORDS=256:
  - SW 0x55AA55AA to 0x400, then LW 0x000 returns 0x55AA55AA.
  - A request held high through DONE is not re-executed; the next request is accepted only in IDLE.
